fifo_arb_ctrl: RTL

Write-arbiter and pointer sequencer that shares one `fifo_mem` storage array between two producers and one consumer. Owns the write/read pointers, occupancy count and full/empty flags, and drives the memory's write enable, write address, write data and read address. Sits directly in front of the storage array; producers see a request/grant handshake, and the consumer sees a valid/pop interface.

---
 rtl/fifo_arb_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_arb_ctrl.sv
// Two-producer write arbiter and pointer sequencer in front of a shared fifo_mem array.
// Define FIFO_ARB_RR_EN for round-robin tie-break; otherwise req0 wins every tie.
module fifo_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 16,
  localparam int AW        = $clog2(ADDR_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  mem_write_en,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [AW-1:0]         mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          last_reg, last_next;
  logic          push, pop;

  assign full  = (count_reg == (AW+1)'(ADDR_SIZE));
  assign empty = (count_reg == '0);

  // Grants are suppressed while full, so a pop at full cannot be paired with a push.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !flush && !full) begin
      if (req0 && req1) begin
`ifdef FIFO_ARB_RR_EN
        if (last_reg) gnt0 = 1'b1;
        else          gnt1 = 1'b1;
`else
        gnt0 = 1'b1;
`endif
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign push = gnt0 | gnt1;
  assign pop  = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    last_next   = last_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        last_next   = gnt1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + (AW+1)'(1);
      end else if (pop && !push) begin
        count_next = count_reg - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      last_reg   <= last_next;
    end
  end

  assign count        = count_reg;
  assign rd_valid     = !empty;
  assign rd_data      = mem_rdata;
  assign mem_write_en = push;
  assign mem_waddr    = wr_ptr_reg;
  assign mem_wdata    = gnt1 ? data1 : data0;
  assign mem_raddr    = rd_ptr_reg;

endmodule
